// File: rtl/frame_capture_controller.sv
// frame_capture_controller
//   Captures one thermostat frame from the decoded Manchester bit stream.
//   It hunts for the 32-bit preamble and then shifts in a 160-bit payload.
//   It checks the fixed type/constant fields and commits a good frame to the
//   output registers. Rejected or aborted frames leave the outputs untouched.
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   bit_valid, bit_data     one-cycle strobe carrying a decoded bit (MSB first)
//   busy                    FSM is in RECEIVE or CHECK
//   frame_valid             one-cycle pulse, output fields just updated
//   frame_error             one-cycle pulse, frame aborted (gap) or rejected
//   thermostat_id, room_temp, set_temp, state   last good frame fields
//   frames_ok, frames_bad   saturating 8-bit frame counters
module frame_capture_controller #(
  parameter logic [31:0] PREAMBLE    = 32'hAAAA_5555,
  parameter logic [15:0] TYPE_1      = 16'h0101,
  parameter logic [15:0] TYPE_2      = 16'h0202,
  parameter logic [31:0] CONSTANT    = 32'hC0DE_0001,
  parameter int          GAP_TIMEOUT = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bit_valid,
  input  logic        bit_data,
  output logic        busy,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [31:0] thermostat_id,
  output logic [15:0] room_temp,
  output logic [15:0] set_temp,
  output logic [7:0]  state,
  output logic [7:0]  frames_ok,
  output logic [7:0]  frames_bad
);

  localparam int            GW       = $clog2(GAP_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {HUNT, RECEIVE, CHECK} fsm_e;

  fsm_e           fsm_q, fsm_d;
  logic [31:0]    window_q, window_d;
  logic [159:0]   payload_q, payload_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  // CHECK verdict is registered, then applied one edge later.
  logic           commit_q, commit_d;
  logic           reject_q, reject_d;
  logic           frame_valid_q, frame_valid_d;
  logic           frame_error_q, frame_error_d;
  logic [31:0]    id_q, id_d;
  logic [15:0]    room_q, room_d;
  logic [15:0]    set_q, set_d;
  logic [7:0]     st_q, st_d;
  logic [7:0]     ok_q, ok_d;
  logic [7:0]     bad_q, bad_d;

  logic [31:0]    win_shift;
  logic           fields_match;
  logic           timeout;

  assign win_shift    = {window_q[30:0], bit_data};
  assign fields_match = (payload_q[159:144] == TYPE_1) &&
                        (payload_q[143:128] == TYPE_2) &&
                        (payload_q[127:96]  == CONSTANT);

  always_comb begin
    fsm_d         = fsm_q;
    window_d      = window_q;
    payload_d     = payload_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    commit_d      = 1'b0;
    reject_d      = 1'b0;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    id_d          = id_q;
    room_d        = room_q;
    set_d         = set_q;
    st_d          = st_q;
    ok_d          = ok_q;
    bad_d         = bad_q;
    timeout       = 1'b0;

    case (fsm_q)
      HUNT: begin
        if (bit_valid) begin
          window_d = win_shift;
          if (win_shift == PREAMBLE) begin
            fsm_d     = RECEIVE;
            bit_cnt_d = 8'd0;
            gap_cnt_d = '0;
            window_d  = 32'd0;
          end
        end
      end
      RECEIVE: begin
        if (bit_valid) begin
          payload_d = {payload_q[158:0], bit_data};
          bit_cnt_d = bit_cnt_q + 8'd1;
          gap_cnt_d = '0;
          if (bit_cnt_q == 8'd159) fsm_d = CHECK;
        end else if (gap_cnt_q == GAP_LAST) begin
          timeout = 1'b1;
          fsm_d   = HUNT;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      CHECK: begin
        // Any strobe arriving here is intentionally ignored.
        fsm_d = HUNT;
        if (fields_match) commit_d = 1'b1;
        else              reject_d = 1'b1;
      end
      default: fsm_d = HUNT;
    endcase

    // The payload register is frozen in HUNT, so it still holds the checked
    // frame when the commit lands.
    if (commit_q) begin
      frame_valid_d = 1'b1;
      id_d          = payload_q[95:64];
      room_d        = payload_q[63:48];
      set_d         = payload_q[47:32];
      st_d          = payload_q[31:24];
      if (ok_q != 8'hFF) ok_d = ok_q + 8'd1;
    end

    if (timeout || reject_q) begin
      frame_error_d = 1'b1;
      if (bad_q != 8'hFF) bad_d = bad_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q         <= HUNT;
      window_q      <= 32'd0;
      payload_q     <= 160'd0;
      bit_cnt_q     <= 8'd0;
      gap_cnt_q     <= '0;
      commit_q      <= 1'b0;
      reject_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      id_q          <= 32'd0;
      room_q        <= 16'd0;
      set_q         <= 16'd0;
      st_q          <= 8'd0;
      ok_q          <= 8'd0;
      bad_q         <= 8'd0;
    end else begin
      fsm_q         <= fsm_d;
      window_q      <= window_d;
      payload_q     <= payload_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      commit_q      <= commit_d;
      reject_q      <= reject_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      id_q          <= id_d;
      room_q        <= room_d;
      set_q         <= set_d;
      st_q          <= st_d;
      ok_q          <= ok_d;
      bad_q         <= bad_d;
    end
  end

  assign busy          = (fsm_q != HUNT);
  assign frame_valid   = frame_valid_q;
  assign frame_error   = frame_error_q;
  assign thermostat_id = id_q;
  assign room_temp     = room_q;
  assign set_temp      = set_q;
  assign state         = st_q;
  assign frames_ok     = ok_q;
  assign frames_bad    = bad_q;

endmodule

// File: tb/tb_frame_capture_controller.sv
// Bench for frame_capture_controller: randomized frames checked against a
// frame-level reference model (whole-frame verdicts, saturating counts).
module tb_frame_capture_controller;

  localparam logic [31:0] PRE  = 32'hAAAA_5555;
  localparam logic [15:0] T1   = 16'h0101;
  localparam logic [15:0] T2   = 16'h0202;
  localparam logic [31:0] CST  = 32'hC0DE_0001;
  localparam int          GAP  = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bit_valid = 1'b0;
  logic        bit_data = 1'b0;
  logic        busy, frame_valid, frame_error;
  logic [31:0] thermostat_id;
  logic [15:0] room_temp, set_temp;
  logic [7:0]  state, frames_ok, frames_bad;

  frame_capture_controller dut (
    .clock(clock), .reset(reset), .bit_valid(bit_valid), .bit_data(bit_data),
    .busy(busy), .frame_valid(frame_valid), .frame_error(frame_error),
    .thermostat_id(thermostat_id), .room_temp(room_temp), .set_temp(set_temp),
    .state(state), .frames_ok(frames_ok), .frames_bad(frames_bad)
  );

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;
  int cyc = 0, last_strobe = 0;
  int fv_count = 0, fe_count = 0, fv_cyc = 0, fe_cyc = 0, excl_viol = 0;
  logic prev_fv = 1'b0, prev_fe = 1'b0;

  // Reference model state: last good fields and expected counters.
  logic [31:0] m_id = 0;
  logic [15:0] m_room = 0, m_set = 0;
  logic [7:0]  m_st = 0;
  int          m_ok = 0, m_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (frame_valid) begin fv_count <= fv_count + 1; fv_cyc <= cyc; end
    if (frame_error) begin fe_count <= fe_count + 1; fe_cyc <= cyc; end
    if ((frame_valid && frame_error) || (frame_valid && prev_fv) || (frame_error && prev_fe))
      excl_viol <= excl_viol + 1;
    prev_fv <= frame_valid;
    prev_fe <= frame_error;
  end

  function automatic logic [191:0] mk_frame(logic [15:0] t1, logic [15:0] t2, logic [31:0] c,
                                            logic [31:0] id, logic [15:0] rm, logic [15:0] st,
                                            logic [7:0] sb, logic [23:0] tail);
    return {PRE, t1, t2, c, id, rm, st, sb, tail};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // sp = 0 picks a random spacing of 1..4 clocks per bit.
  task automatic send_bit(input logic b, input int sp);
    int s;
    s = (sp == 0) ? $urandom_range(1, 4) : sp;
    bit_valid = 1'b1; bit_data = b;
    @(posedge clock); #1;
    last_strobe = cyc;
    bit_valid = 1'b0;
    wait_cycles(s - 1);
  endtask

  task automatic send_bits(input logic [191:0] f, input int hi, input int lo, input int sp);
    for (int i = hi; i >= lo; i--) send_bit(f[i], sp);
  endtask

  task automatic model_commit(input logic [191:0] f);
    m_id = f[95:64]; m_room = f[63:48]; m_set = f[47:32]; m_st = f[31:24];
    if (m_ok < 255) m_ok++;
  endtask

  task automatic model_reject();
    if (m_bad < 255) m_bad++;
  endtask

  task automatic test_reset();
    wait_cycles(3);
    vectors++;
    if ({busy, frame_valid, frame_error} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b, expected 000", {busy, frame_valid, frame_error});
    end
    reset = 1'b0;
    wait_cycles(2);
    vectors++;
    if ({thermostat_id, room_temp, set_temp, state} !== 72'd0) begin
      miscompares++; $display("FAIL reset_fields: got %0h, expected 0", {thermostat_id, room_temp, set_temp, state});
    end
    vectors++;
    if ({frames_ok, frames_bad, busy} !== 17'd0) begin
      miscompares++; $display("FAIL reset_counters: got %0h, expected 0", {frames_ok, frames_bad, busy});
    end
  endtask

  task automatic test_good_frame();
    logic [191:0] f;
    int fv0;
    f = mk_frame(T1, T2, CST, 32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03, 24'h0);
    fv0 = fv_count;
    send_bits(f, 191, 0, 8);
    wait_cycles(2);
    model_commit(f);
    vectors++;
    if (fv_count - fv0 !== 1) begin
      miscompares++; $display("FAIL good_pulses: got %0d, expected 1", fv_count - fv0);
    end
    vectors++;
    if (fv_cyc - last_strobe !== 2) begin
      miscompares++; $display("FAIL good_latency: got %0d, expected 2", fv_cyc - last_strobe);
    end
    vectors++;
    if ({thermostat_id, room_temp, set_temp, state} !== {m_id, m_room, m_set, m_st}) begin
      miscompares++; $display("FAIL good_fields: got %0h, expected %0h",
        {thermostat_id, room_temp, set_temp, state}, {m_id, m_room, m_set, m_st});
    end
    vectors++;
    if (frames_ok !== 8'(m_ok) || frames_bad !== 8'(m_bad)) begin
      miscompares++; $display("FAIL good_counts: got %0d/%0d, expected %0d/%0d", frames_ok, frames_bad, m_ok, m_bad);
    end
  endtask

  task automatic test_bad_constant();
    logic [191:0] f;
    int fe0, fv0;
    f = mk_frame(T1, T2, 32'hC0DE_0002, 32'hDEAD_BEEF, 16'h1111, 16'h2222, 8'h44, 24'h0);
    fe0 = fe_count; fv0 = fv_count;
    send_bits(f, 191, 0, 8);
    model_reject();
    vectors++;
    if (fe_count - fe0 !== 1 || fv_count !== fv0) begin
      miscompares++; $display("FAIL badconst_pulses: got err %0d val %0d, expected err 1 val 0", fe_count - fe0, fv_count - fv0);
    end
    vectors++;
    if ({thermostat_id, room_temp, set_temp, state} !== {m_id, m_room, m_set, m_st}) begin
      miscompares++; $display("FAIL badconst_hold: got %0h, expected %0h",
        {thermostat_id, room_temp, set_temp, state}, {m_id, m_room, m_set, m_st});
    end
    vectors++;
    if (frames_bad !== 8'(m_bad) || frames_ok !== 8'(m_ok)) begin
      miscompares++; $display("FAIL badconst_counts: got %0d/%0d, expected %0d/%0d", frames_ok, frames_bad, m_ok, m_bad);
    end
  endtask

  // Noise whose first preamble match (window starting at 0) is exactly the
  // trailing preamble copy.
  task automatic test_noise_lock();
    bit q[$];
    logic [31:0] w;
    int first, n, tries;
    logic [191:0] f;
    int fv0;
    tries = 0;
    do begin
      q.delete();
      n = $urandom_range(40, 120);
      for (int i = 0; i < n; i++) q.push_back(1'($urandom_range(0, 1)));
      for (int i = 31; i >= 0; i--) q.push_back(PRE[i]);
      w = 0; first = -1;
      for (int i = 0; i < q.size(); i++) begin
        w = {w[30:0], q[i]};
        if (w == PRE && first < 0) first = i;
      end
      tries++;
    end while (first != q.size() - 1 && tries < 100);
    f = mk_frame(T1, T2, CST, $urandom, 16'($urandom), 16'($urandom), 8'($urandom), 24'($urandom));
    fv0 = fv_count;
    for (int i = 0; i < q.size(); i++) send_bit(q[i], 0);
    send_bits(f, 159, 0, 0);
    wait_cycles(3);
    model_commit(f);
    vectors++;
    if (fv_count - fv0 !== 1) begin
      miscompares++; $display("FAIL noise_lock: got %0d pulses, expected 1", fv_count - fv0);
    end
    vectors++;
    if ({thermostat_id, room_temp, set_temp, state} !== {m_id, m_room, m_set, m_st}) begin
      miscompares++; $display("FAIL noise_fields: got %0h, expected %0h",
        {thermostat_id, room_temp, set_temp, state}, {m_id, m_room, m_set, m_st});
    end
  endtask

  task automatic test_gap_timeout();
    logic [191:0] f;
    int fe0, fv0;
    f = mk_frame(T1, T2, CST, $urandom, 16'($urandom), 16'($urandom), 8'($urandom), 24'($urandom));
    fe0 = fe_count;
    send_bits(f, 191, 110, 1);  // preamble + 50 payload bits
    wait_cycles(100);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL gap_busy_high: got %b, expected 1", busy);
    end
    for (int i = 0; i < 5000 && fe_count == fe0; i++) wait_cycles(1);
    model_reject();
    vectors++;
    if (fe_count - fe0 !== 1) begin
      miscompares++; $display("FAIL gap_pulse: got %0d, expected 1", fe_count - fe0);
    end
    vectors++;
    if (fe_cyc - last_strobe !== GAP) begin
      miscompares++; $display("FAIL gap_latency: got %0d, expected %0d", fe_cyc - last_strobe, GAP);
    end
    vectors++;
    if (busy !== 1'b0 || frames_bad !== 8'(m_bad)) begin
      miscompares++; $display("FAIL gap_after: got busy %b bad %0d, expected busy 0 bad %0d", busy, frames_bad, m_bad);
    end
    f = mk_frame(T1, T2, CST, $urandom, 16'($urandom), 16'($urandom), 8'($urandom), 24'($urandom));
    fv0 = fv_count;
    send_bits(f, 191, 0, 1);
    wait_cycles(3);
    model_commit(f);
    vectors++;
    if (fv_count - fv0 !== 1 || thermostat_id !== m_id || frames_ok !== 8'(m_ok)) begin
      miscompares++; $display("FAIL gap_recover: got %0d pulses id %0h ok %0d, expected 1 %0h %0d",
        fv_count - fv0, thermostat_id, frames_ok, m_id, m_ok);
    end
  endtask

  task automatic test_reset_mid();
    logic [191:0] f;
    int fv0;
    f = mk_frame(T1, T2, CST, $urandom, 16'($urandom), 16'($urandom), 8'($urandom), 24'($urandom));
    send_bits(f, 191, 80, 1);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    m_id = 0; m_room = 0; m_set = 0; m_st = 0; m_ok = 0; m_bad = 0;
    vectors++;
    if ({thermostat_id, room_temp, set_temp, state, frames_ok, frames_bad} !== 88'd0) begin
      miscompares++; $display("FAIL midreset_zero: got %0h, expected 0",
        {thermostat_id, room_temp, set_temp, state, frames_ok, frames_bad});
    end
    vectors++;
    if ({busy, frame_valid, frame_error} !== 3'b000) begin
      miscompares++; $display("FAIL midreset_hunt: got %b, expected 000", {busy, frame_valid, frame_error});
    end
    f = mk_frame(T1, T2, CST, $urandom, 16'($urandom), 16'($urandom), 8'($urandom), 24'($urandom));
    fv0 = fv_count;
    send_bits(f, 191, 0, 0);
    wait_cycles(3);
    model_commit(f);
    vectors++;
    if (fv_count - fv0 !== 1 || {thermostat_id, room_temp, set_temp, state} !== {m_id, m_room, m_set, m_st}
        || frames_ok !== 8'(m_ok)) begin
      miscompares++; $display("FAIL midreset_recover: got %0d pulses fields %0h ok %0d, expected 1 %0h %0d",
        fv_count - fv0, {thermostat_id, room_temp, set_temp, state}, frames_ok, {m_id, m_room, m_set, m_st}, m_ok);
    end
  endtask

  task automatic test_random_frames();
    logic [191:0] f;
    logic [15:0] t1, t2;
    logic [31:0] c;
    bit good;
    int fv0, fe0, k;
    for (int n = 0; n < 12; n++) begin
      t1 = T1; t2 = T2; c = CST;
      good = ($urandom_range(0, 3) != 0);
      if (!good) begin
        k = $urandom_range(0, 2);
        if (k == 0)      t1 = t1 ^ (16'd1 << $urandom_range(0, 15));
        else if (k == 1) t2 = t2 ^ (16'd1 << $urandom_range(0, 15));
        else             c  = c  ^ (32'd1 << $urandom_range(0, 31));
      end
      f = mk_frame(t1, t2, c, $urandom, 16'($urandom), 16'($urandom), 8'($urandom), 24'($urandom));
      fv0 = fv_count; fe0 = fe_count;
      send_bits(f, 191, 0, 0);
      wait_cycles(3);
      if (good) model_commit(f); else model_reject();
      vectors++;
      if (fv_count - fv0 !== int'(good) || fe_count - fe0 !== int'(!good)) begin
        miscompares++; $display("FAIL rand_verdict[%0d]: got val %0d err %0d, expected val %0d err %0d",
          n, fv_count - fv0, fe_count - fe0, good, !good);
      end
      vectors++;
      if ({thermostat_id, room_temp, set_temp, state, frames_ok, frames_bad} !==
          {m_id, m_room, m_set, m_st, 8'(m_ok), 8'(m_bad)}) begin
        miscompares++; $display("FAIL rand_state[%0d]: got %0h, expected %0h", n,
          {thermostat_id, room_temp, set_temp, state, frames_ok, frames_bad},
          {m_id, m_room, m_set, m_st, 8'(m_ok), 8'(m_bad)});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [191:0] f;
    int fv0;
    fv0 = fv_count;
    for (int n = 0; n < 300; n++) begin
      f = mk_frame(T1, T2, CST, $urandom, 16'($urandom), 16'($urandom), 8'($urandom), 24'($urandom));
      send_bits(f, 191, 0, 1);
      wait_cycles(1);  // the strobe slot right after the last bit falls in CHECK
      model_commit(f);
    end
    wait_cycles(3);
    vectors++;
    if (fv_count - fv0 !== 300) begin
      miscompares++; $display("FAIL b2b_pulses: got %0d, expected 300", fv_count - fv0);
    end
    vectors++;
    if (frames_ok !== 8'(m_ok) || m_ok != 255) begin
      miscompares++; $display("FAIL b2b_saturate: got %0d, expected %0d", frames_ok, m_ok);
    end
    vectors++;
    if ({thermostat_id, room_temp, set_temp, state} !== {m_id, m_room, m_set, m_st}) begin
      miscompares++; $display("FAIL b2b_fields: got %0h, expected %0h",
        {thermostat_id, room_temp, set_temp, state}, {m_id, m_room, m_set, m_st});
    end
    vectors++;
    if (excl_viol !== 0) begin
      miscompares++; $display("FAIL pulse_exclusive: got %0d violations, expected 0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_constant();
    test_noise_lock();
    test_gap_timeout();
    test_reset_mid();
    test_random_frames();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
